pll_reconfig_seq: RTL

- Parametrised sequencer that retunes a reconfigurable fractional PLL at run time, e.g. switching between PAL and NTSC system clock sets.
- Latches a full counter configuration on request and drives the PLL reconfiguration controller's Avalon-MM management port.
- Starts the reconfiguration, polls for completion, then waits for PLL relock.
- Sits between the core's video-standard/mode logic and the PLL + reconfig controller pair.

---
 rtl/pll_reconfig_pkg.sv | 46 ++++
 rtl/pll_mgmt_master.sv | 48 ++++
 rtl/pll_reconfig_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the PLL reconfiguration sequencer:
// FSM states, reconfig-controller register map and C-word packing.
package pll_reconfig_pkg;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 18;   // {odd, bypass, hi[7:0], lo[7:0]}
  localparam int C_IDX_LSB = 18;
  localparam int C_IDX_W   = 5;

  typedef enum logic [ADDR_W-1:0] {
    REG_MODE   = 6'd0,
    REG_STATUS = 6'd1,
    REG_START  = 6'd2,
    REG_N      = 6'd3,
    REG_M      = 6'd4,
    REG_C      = 6'd5,
    REG_K      = 6'd7,
    REG_BW     = 6'd8,
    REG_CP     = 6'd9
  } reg_addr_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_MODE,
    ST_WR_N,
    ST_WR_M,
    ST_WR_K,
    ST_WR_C,
    ST_WR_BW,
    ST_WR_CP,
    ST_WR_START,
    ST_POLL,
    ST_LOCK
  } state_t;

  function automatic logic [DATA_W-1:0] c_word(input logic [C_IDX_W-1:0] idx,
                                                input logic [CNT_W-1:0]   cnt);
    logic [DATA_W-1:0] w;
    w = '0;
    w[C_IDX_LSB +: C_IDX_W] = idx;
    w[CNT_W-1:0]            = cnt;
    return w;
  endfunction

endpackage

// File: rtl/pll_mgmt_master.sv
// Single-outstanding Avalon-MM master: issues one read or write when asked,
// holds it through waitrequest, and acks in the cycle the access completes.
module pll_mgmt_master
  import pll_reconfig_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              abort,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mgmt_address,
  output logic              mgmt_write,
  output logic              mgmt_read,
  output logic [DATA_W-1:0] mgmt_writedata,
  input  logic [DATA_W-1:0] mgmt_readdata,
  input  logic              mgmt_waitrequest
);

  logic active;

  assign active = mgmt_write | mgmt_read;
  assign ack    = active & ~mgmt_waitrequest;
  assign rdata  = mgmt_readdata;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mgmt_address   <= '0;
      mgmt_write     <= 1'b0;
      mgmt_read      <= 1'b0;
      mgmt_writedata <= '0;
    end else if (abort || ack) begin
      mgmt_write <= 1'b0;
      mgmt_read  <= 1'b0;
    end else if (!active && req) begin
      mgmt_address   <= cmd_addr;
      mgmt_writedata <= cmd_write ? cmd_data : '0;
      mgmt_write     <= cmd_write;
      mgmt_read      <= ~cmd_write;
    end
  end

endmodule

// File: rtl/pll_reconfig_seq.sv
// Run-time PLL retune sequencer: writes mode/N/M/K/C(/BW/CP), starts, polls,
// then waits for relock. Optional BW/CP writes under macro PLL_RECONF_BW_EN.
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int          NUM_CLK   = 3,
  parameter int          TIMEOUT   = 65535,
  parameter logic [31:0] MODE_POLL = 32'd1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic [CNT_W-1:0]         n_cfg,
  input  logic [CNT_W-1:0]         m_cfg,
  input  logic [31:0]              k_cfg,
  input  logic [CNT_W*NUM_CLK-1:0] c_cfg,
  input  logic [NUM_CLK-1:0]       c_mask,
  input  logic [3:0]               bw_cfg,
  input  logic [2:0]               cp_cfg,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [ADDR_W-1:0]        mgmt_address,
  output logic                     mgmt_write,
  output logic                     mgmt_read,
  output logic [DATA_W-1:0]        mgmt_writedata,
  input  logic [DATA_W-1:0]        mgmt_readdata,
  input  logic                     mgmt_waitrequest,
  input  logic                     pll_locked
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                   state;
  logic [CNT_W-1:0]         n_q, m_q;
  logic [31:0]              k_q;
  logic [CNT_W*NUM_CLK-1:0] c_q;
  logic [NUM_CLK-1:0]       mask_q;
  logic [C_IDX_W-1:0]       c_idx;
  logic [TW-1:0]            tmo_cnt;
  logic [1:0]               lock_sync;
  logic                     lock_prev;

  logic                     bus_req, cmd_write, ack, abort;
  logic [ADDR_W-1:0]        cmd_addr;
  logic [DATA_W-1:0]        cmd_data, rdata;
  logic                     poll_ok, lock_ok, tmo_hit;
  logic [C_IDX_W:0]         c_first, c_after;
  state_t                   post_c;

  // Lowest set mask bit at or above 'from'; MSB of the result flags "found".
  function automatic logic [C_IDX_W:0] next_set(input logic [NUM_CLK-1:0] mask,
                                                input int from);
    logic [C_IDX_W:0] r;
    r = '0;
    for (int i = NUM_CLK - 1; i >= 0; i--)
      if (i >= from && mask[i]) r = {1'b1, C_IDX_W'(i)};
    return r;
  endfunction

  assign c_first = next_set(mask_q, 0);
  assign c_after = next_set(mask_q, int'(c_idx) + 1);

`ifdef PLL_RECONF_BW_EN
  logic [3:0] bw_q;
  logic [2:0] cp_q;
  assign post_c = ST_WR_BW;
`else
  logic unused_bw_cp;
  assign unused_bw_cp = ^{bw_cfg, cp_cfg};
  assign post_c = ST_WR_START;
`endif

  logic unused_rdata;
  assign unused_rdata = ^rdata[DATA_W-1:1];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bus_req   = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = REG_MODE;
    cmd_data  = '0;
    case (state)
      ST_WR_MODE:  cmd_data = MODE_POLL;
      ST_WR_N:     begin cmd_addr = REG_N; cmd_data = {14'd0, n_q}; end
      ST_WR_M:     begin cmd_addr = REG_M; cmd_data = {14'd0, m_q}; end
      ST_WR_K:     begin cmd_addr = REG_K; cmd_data = k_q; end
      ST_WR_C:     begin
        cmd_addr = REG_C;
        cmd_data = c_word(c_idx, c_q[CNT_W*int'(c_idx) +: CNT_W]);
      end
`ifdef PLL_RECONF_BW_EN
      ST_WR_BW:    begin cmd_addr = REG_BW; cmd_data = {28'd0, bw_q}; end
      ST_WR_CP:    begin cmd_addr = REG_CP; cmd_data = {29'd0, cp_q}; end
`endif
      ST_WR_START: begin cmd_addr = REG_START; cmd_data = 32'd1; end
      ST_POLL:     begin cmd_write = 1'b0; cmd_addr = REG_STATUS; end
      default:     bus_req = 1'b0;
    endcase
  end

  // Completion beats a coincident timeout.
  assign poll_ok = (state == ST_POLL) && ack && rdata[0];
  assign lock_ok = (state == ST_LOCK) && lock_sync[1] && lock_prev;
  assign tmo_hit = ((state == ST_POLL) || (state == ST_LOCK)) &&
                   (tmo_cnt == TW'(TIMEOUT - 1));
  assign abort   = tmo_hit && !poll_ok && !lock_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync <= '0;
      lock_prev <= 1'b0;
    end else begin
      lock_sync <= {lock_sync[0], pll_locked};
      lock_prev <= lock_sync[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      // NOTE: the captured configuration is reset too; it is a handful of
      // flops, not a RAM, and a known value keeps the bus data deterministic.
      n_q     <= '0;
      m_q     <= '0;
      k_q     <= '0;
      c_q     <= '0;
      mask_q  <= '0;
      c_idx   <= '0;
      tmo_cnt <= '0;
`ifdef PLL_RECONF_BW_EN
      bw_q    <= '0;
      cp_q    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (req) begin
          n_q    <= n_cfg;
          m_q    <= m_cfg;
          k_q    <= k_cfg;
          c_q    <= c_cfg;
          mask_q <= c_mask;
`ifdef PLL_RECONF_BW_EN
          bw_q   <= bw_cfg;
          cp_q   <= cp_cfg;
`endif
          busy   <= 1'b1;
          error  <= 1'b0;
          state  <= ST_WR_MODE;
        end
        ST_WR_MODE: if (ack) state <= ST_WR_N;
        ST_WR_N:    if (ack) state <= ST_WR_M;
        ST_WR_M:    if (ack) state <= ST_WR_K;
        ST_WR_K: if (ack) begin
          if (c_first[C_IDX_W]) begin
            c_idx <= c_first[C_IDX_W-1:0];
            state <= ST_WR_C;
          end else begin
            state <= post_c;
          end
        end
        ST_WR_C: if (ack) begin
          if (c_after[C_IDX_W]) c_idx <= c_after[C_IDX_W-1:0];
          else                  state <= post_c;
        end
`ifdef PLL_RECONF_BW_EN
        ST_WR_BW:   if (ack) state <= ST_WR_CP;
        ST_WR_CP:   if (ack) state <= ST_WR_START;
`endif
        ST_WR_START: if (ack) begin
          tmo_cnt <= '0;
          state   <= ST_POLL;
        end
        ST_POLL, ST_LOCK: begin
          if (poll_ok) begin
            tmo_cnt <= '0;
            state   <= ST_LOCK;
          end else if (lock_ok) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (tmo_hit) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pll_mgmt_master u_master (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (bus_req),
    .abort            (abort),
    .cmd_write        (cmd_write),
    .cmd_addr         (cmd_addr),
    .cmd_data         (cmd_data),
    .ack              (ack),
    .rdata            (rdata),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_read        (mgmt_read),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest)
  );

endmodule
